// File: rtl/dpfp_divider_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dpfp_divider_seq_if
// Purpose  : Start/busy/done handshake bundle for the sequential DP divider.
//            master = requester (drives start, a, b)
//            slave  = divider   (drives busy, done, result, div_zero, invalid)
// Ports    : start, a, b, busy, done, result, div_zero, invalid
// Revision : 1.0 - initial release
// ============================================================================
interface dpfp_divider_seq_if #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
);
    localparam int c_W = EXP_W + FRAC_W + 1;

    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           busy;
    logic           done;
    logic [c_W-1:0] result;
    logic           div_zero;
    logic           invalid;

    modport master (
        output start, a, b,
        input  busy, done, result, div_zero, invalid
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, div_zero, invalid
    );
endinterface
`default_nettype wire

// File: rtl/dpfp_divider_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dpfp_divider_seq
// Purpose  : Sequential IEEE-754 double-precision divider, result = a / b.
//            Radix-2 restoring mantissa division (one quotient bit per
//            clock), round-to-nearest-even, denormal inputs flushed to zero,
//            no subnormal outputs.
// Ports    : clk      - rising-edge clock
//            rst_n    - asynchronous active-low reset
//            bus      - slave side of dpfp_divider_seq_if
//                       (start/a/b in; busy/done/result/div_zero/invalid out)
// Revision : 1.0 - initial release
// ============================================================================
module dpfp_divider_seq #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    dpfp_divider_seq_if.slave    bus
);
    localparam int c_W     = EXP_W + FRAC_W + 1;
    localparam int c_MW    = FRAC_W + 1;          // mantissa incl. hidden bit
    localparam int c_QN    = FRAC_W + 3;          // quotient bits
    localparam int c_EW    = EXP_W + 2;           // signed working exponent
    localparam int c_CNT_W = $clog2(c_QN + 1);
    localparam int c_BIAS  = 2**(EXP_W-1) - 1;

    localparam logic signed [c_EW-1:0] c_EXP_MAX  = c_EW'((2**EXP_W) - 1);
    localparam logic signed [c_EW-1:0] c_EXP_ZERO = '0;
    localparam logic signed [c_EW-1:0] c_EXP_ONE  = c_EW'(1);
    localparam logic [c_W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CHECK = 3'd1;
    localparam logic [2:0] c_ST_DIV   = 3'd2;
    localparam logic [2:0] c_ST_NORM  = 3'd3;
    localparam logic [2:0] c_ST_ROUND = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [c_W-1:0]          r_a;
    logic [c_W-1:0]          r_b;
    logic                    r_sign;
    logic signed [c_EW-1:0]  r_exp;
    logic [c_QN-1:0]         r_rem;
    logic [c_MW-1:0]         r_div;
    logic [c_QN-1:0]         r_q;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_sticky;
    logic [c_W-1:0]          r_result;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_dz;
    logic                    r_inv;

    // ------------------------------------------------------------------
    // Operand classification (from captured operands)
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [FRAC_W-1:0] w_fa, w_fb;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sign;
    logic signed [c_EW-1:0] w_exp_init;
    logic [c_W-1:0] w_inf_chk, w_zero_chk;

    assign w_ea     = r_a[c_W-2 -: EXP_W];
    assign w_eb     = r_b[c_W-2 -: EXP_W];
    assign w_fa     = r_a[FRAC_W-1:0];
    assign w_fb     = r_b[FRAC_W-1:0];
    // Exponent field of zero means zero: denormals are flushed.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) && (w_fa == '0);
    assign w_b_inf  = (&w_eb) && (w_fb == '0);
    assign w_a_nan  = (&w_ea) && (w_fa != '0);
    assign w_b_nan  = (&w_eb) && (w_fb != '0);
    assign w_sign   = r_a[c_W-1] ^ r_b[c_W-1];

    assign w_exp_init = c_EW'({2'b00, w_ea}) - c_EW'({2'b00, w_eb}) + c_EW'(c_BIAS);
    assign w_inf_chk  = {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    assign w_zero_chk = {w_sign, {(c_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Restoring division step. The remainder always stays below twice the
    // divisor, so two extra bits above the mantissa are enough headroom.
    // ------------------------------------------------------------------
    logic            w_ge;
    logic [c_QN-1:0] w_rem_sub;

    assign w_ge      = (r_rem >= {2'b00, r_div});
    assign w_rem_sub = w_ge ? (r_rem - {2'b00, r_div}) : r_rem;

    // ------------------------------------------------------------------
    // Round-to-nearest-even on the normalised quotient
    // ------------------------------------------------------------------
    logic [c_MW-1:0]        w_mant;
    logic                   w_guard, w_stk, w_rup, w_carry;
    logic [c_MW:0]          w_mant_inc;
    logic [FRAC_W-1:0]      w_frac_fin;
    logic signed [c_EW-1:0] w_exp_rnd;
    logic [c_W-1:0]         w_res_rnd;

    assign w_mant     = r_q[c_QN-1:2];
    assign w_guard    = r_q[1];
    assign w_stk      = r_sticky | r_q[0];
    assign w_rup      = w_guard & (w_stk | w_mant[0]);
    assign w_mant_inc = {1'b0, w_mant} + (c_MW+1)'(w_rup);
    assign w_carry    = w_mant_inc[c_MW];
    // On carry-out the mantissa is exactly 2.0, so dropping the LSB is the shift.
    assign w_frac_fin = w_carry ? w_mant_inc[c_MW-1:1] : w_mant_inc[FRAC_W-1:0];
    assign w_exp_rnd  = w_carry ? (r_exp + c_EXP_ONE) : r_exp;

    always_comb begin
        w_res_rnd = {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_fin};
        if (w_exp_rnd >= c_EXP_MAX) begin
            w_res_rnd = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (w_exp_rnd <= c_EXP_ZERO) begin
            w_res_rnd = {r_sign, {(c_W-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic w_special;
    assign w_special = w_a_nan | w_b_nan | w_a_zero | w_b_zero | w_a_inf | w_b_inf;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.start) w_state_nxt = c_ST_CHECK;
            c_ST_CHECK: w_state_nxt = w_special ? c_ST_DONE : c_ST_DIV;
            c_ST_DIV:   if (r_cnt == c_CNT_W'(1)) w_state_nxt = c_ST_NORM;
            c_ST_NORM:  w_state_nxt = c_ST_ROUND;
            c_ST_ROUND: w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_busy <= 1'b1;
                        r_dz   <= 1'b0;
                        r_inv  <= 1'b0;
                    end
                end
                c_ST_CHECK: begin
                    r_sign <= w_sign;
                    if (w_a_nan || w_b_nan) begin
                        r_result <= c_QNAN;
                    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
                        r_result <= c_QNAN;
                        r_inv    <= 1'b1;
                    end else if (w_b_zero && !w_a_inf) begin
                        r_result <= w_inf_chk;
                        r_dz     <= 1'b1;
                    end else if (w_a_inf) begin
                        r_result <= w_inf_chk;
                    end else if (w_b_inf || w_a_zero) begin
                        r_result <= w_zero_chk;
                    end else begin
                        r_exp <= w_exp_init;
                        r_rem <= {2'b00, 1'b1, w_fa};
                        r_div <= {1'b1, w_fb};
                        r_q   <= '0;
                        r_cnt <= c_CNT_W'(c_QN);
                    end
                end
                c_ST_DIV: begin
                    r_q   <= {r_q[c_QN-2:0], w_ge};
                    r_rem <= w_rem_sub << 1;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                c_ST_NORM: begin
                    // Quotient lies in (0.5, 2): at most one left shift.
                    if (!r_q[c_QN-1]) begin
                        r_q   <= r_q << 1;
                        r_exp <= r_exp - c_EXP_ONE;
                    end
                    r_sticky <= (r_rem != '0);
                end
                c_ST_ROUND: begin
                    r_result <= w_res_rnd;
                end
                c_ST_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.div_zero = r_dz;
    assign bus.invalid  = r_inv;

endmodule
`default_nettype wire
